// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Ops 0-3 occupy the unit for several cycles; 4-7 never do.
    function automatic logic is_long_op(input logic [2:0] op);
        return ~op[2];
    endfunction

    // Divides are ops 2 and 3.
    function automatic logic is_div_op(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_counter.sv
// Loadable down-counter that times an in-flight multiply/divide.
module md_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             is_one,
    output logic             nonzero
);

    logic [WIDTH-1:0] count_q;

    // Load on issue, otherwise count down to zero and stop there.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count   = count_q;
    assign is_one  = (count_q == WIDTH'(1));
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: executes MD ops into private HI/LO and raises the pipeline stall.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_is_one;
    logic             cnt_nz;
    logic             issue;

    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] div_b_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0] div_b_u;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_ovf;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    // A long op is only accepted while idle; Start during RUN is dropped.
    assign issue        = Start & is_long_op(MDOp) & ~cnt_nz;
    assign cnt_load_val = is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (issue),
        .load_val (cnt_load_val),
        .count    (cnt_value),
        .is_one   (cnt_is_one),
        .nonzero  (cnt_nz)
    );

    // Stall covers the issue cycle combinationally, then the whole RUN window.
    assign Busy = (Start & is_long_op(MDOp)) | cnt_nz;

    // Signed product via sign-extended 64-bit multiply; low 64 bits are exact.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Divisor is forced to 1 for x/0 (result discarded) and for INT_MIN/-1, where
    // dividing by 1 yields exactly the required LO = INT_MIN, HI = 0 without overflow.
    assign a_s     = a_q;
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign div_b_s = ((b_q == 32'd0) || div_ovf) ? 32'sd1 : $signed(b_q);
    assign div_b_u = (b_q == 32'd0) ? 32'd1 : b_q;
    assign quot_s  = a_s / div_b_s;
    assign rem_s   = a_s % div_b_s;
    assign quot_u  = a_q / div_b_u;
    assign rem_u   = a_q % div_b_u;

    // Select the result of the latched op; divide by zero suppresses the write.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        case (op_q)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
                res_wr = (b_q != 32'd0);
            end
            MD_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
                res_wr = (b_q != 32'd0);
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    // Operand latch on issue, HI/LO update on completion or on an idle mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= 3'd0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (issue) begin
                op_q <= MDOp;
                a_q  <= RsData;
                b_q  <= RtData;
            end
            if (cnt_is_one) begin
                if (res_wr) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else if (!cnt_nz && Start) begin
                if (MDOp == MD_MTHI) begin
                    hi_q <= RsData;
                end else if (MDOp == MD_MTLO) begin
                    lo_q <= RsData;
                end
            end
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vectors plus random ops against a behavioural model.
module tb_md_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = 3'd7;
    logic [31:0] RsData = '0;
    logic [31:0] RtData = '0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    md_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .MDOp   (MDOp),
        .RsData (RsData),
        .RtData (RtData),
        .HI     (HI),
        .LO     (LO),
        .Busy   (Busy)
    );

    always #5 clk = ~clk;

    // Architectural model: what HI/LO become after op completes, from plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi_in, input logic [31:0] lo_in,
                                  output logic [31:0] hi_out, output logic [31:0] lo_out);
        longint sa;
        longint sb;
        longint p;
        longint unsigned pu;
        hi_out = hi_in;
        lo_out = lo_in;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                p = sa * sb;
                hi_out = p[63:32];
                lo_out = p[31:0];
            end
            3'd1: begin
                pu = longint'({32'b0, a}) * longint'({32'b0, b});
                hi_out = pu[63:32];
                lo_out = pu[31:0];
            end
            3'd2: if (b != 0) begin
                p = sa / sb;
                lo_out = p[31:0];
                p = sa % sb;
                hi_out = p[31:0];
            end
            3'd3: if (b != 0) begin
                lo_out = a / b;
                hi_out = a % b;
            end
            3'd4: hi_out = a;
            3'd5: lo_out = a;
            default: ;
        endcase
    endfunction

    task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        Start  = st;
        MDOp   = op;
        RsData = a;
        RtData = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", HI, 32'd0); end
        checks++;
        if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", LO, 32'd0); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        // Busy follows Start even under reset.
        drive(1'b1, 3'd0, 32'd3, 32'd4);
        #1;
        checks++;
        if (Busy !== 1'b1) begin failures++; $display("FAIL reset_busy_start got=%b exp=1", Busy); end
        // Reset wins over an mthi on the same edge.
        drive(1'b1, 3'd4, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        #1;
        checks++;
        if (HI !== 32'd0) begin failures++; $display("FAIL reset_prio_hi got=%h exp=%h", HI, 32'd0); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL reset_prio_busy got=%b exp=0", Busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2};
        logic [31:0] as   [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs   [5] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ehi  [5] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] elo  [5] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                  32'h8000_0000};
        for (int v = 0; v < 5; v++) begin
            int lat;
            lat = ops[v][1] ? DC : MC;
            for (int c = 0; c <= lat; c++) begin
                if (c == 0) drive(1'b1, ops[v], as[v], bs[v]);
                else drive(1'b0, 3'd7, 32'd0, 32'd0);
                #1;
                checks++;
                if (Busy !== 1'b1) begin
                    failures++;
                    $display("FAIL dir%0d_busy_c%0d got=%b exp=1", v, c, Busy);
                end
                @(negedge clk);
            end
            #1;
            checks++;
            if (Busy !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_end got=%b exp=0", v, Busy); end
            checks++;
            if (HI !== ehi[v]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", v, HI, ehi[v]); end
            checks++;
            if (LO !== elo[v]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", v, LO, elo[v]); end
        end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] hi0;
        hi0 = HI;
        drive(1'b1, 3'd4, 32'h1234_5678, 32'd0);
        #1;
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
        @(negedge clk);
        drive(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0);
        #1;
        checks++;
        if (HI !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", HI); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", Busy); end
        @(negedge clk);
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        #1;
        checks++;
        if (LO !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", LO); end
        checks++;
        if (HI !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", HI); end
        checks++;
        if (hi0 === HI) begin failures++; $display("FAIL mthi_changed got=%h old=%h", HI, hi0); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 3'd4, 32'hA5A5_A5A5, 32'd0);
        @(negedge clk);
        drive(1'b1, 3'd5, 32'h5A5A_5A5A, 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1'b1, 3'd2, 32'd100, 32'd7);
            else drive(1'b0, 3'd7, 32'd0, 32'd0);
            if (c == 4) reset = 1'b1;
            #1;
            if (c == 4) begin
                checks++;
                if (Busy !== 1'b1) begin failures++; $display("FAIL abort_busy_c4 got=%b exp=1", Busy); end
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy_c5 got=%b exp=0", Busy); end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL abort_hilo got=%h/%h exp=0/0", HI, LO);
        end
        repeat (DC + 2) @(negedge clk);
        #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_late got=%h/%h busy=%b exp=0/0 busy=0", HI, LO, Busy);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        for (int c = 0; c <= MC; c++) begin
            case (c)
                0: drive(1'b1, 3'd0, 32'd3, 32'd4);
                2: drive(1'b1, 3'd2, 32'd100, 32'd5);
                3: drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0);
                5: drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
                default: drive(1'b0, 3'd7, 32'd0, 32'd0);
            endcase
            #1;
            checks++;
            if (Busy !== 1'b1) begin failures++; $display("FAIL ign_busy_c%0d got=%b exp=1", c, Busy); end
            @(negedge clk);
        end
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd12) begin
            failures++;
            $display("FAIL ign_result got=%h/%h exp=0/c", HI, LO);
        end
        @(negedge clk);
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
            failures++;
            $display("FAIL ign_after got=%h/%h busy=%b exp=0/c busy=0", HI, LO, Busy);
        end
        @(negedge clk);
    endtask

    // Random ops issued back-to-back; each new op goes out in the first non-busy cycle.
    task automatic test_back_to_back_random();
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic [31:0] nhi;
        logic [31:0] nlo;
        mhi = HI === 32'd0 ? 32'd0 : 32'd0;
        mlo = 32'd12;
        mhi = 32'd0;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int lat;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: a = -32'($urandom_range(1, 1000));
                default: ;
            endcase
            #1;
            checks++;
            if (Busy !== 1'b0 || HI !== mhi || LO !== mlo) begin
                failures++;
                $display("FAIL rnd%0d_pre got=%h/%h busy=%b exp=%h/%h busy=0", i, HI, LO, Busy, mhi, mlo);
            end
            drive(1'b1, op, a, b);
            #1;
            checks++;
            if (Busy !== (op <= 3'd3)) begin
                failures++;
                $display("FAIL rnd%0d_issue_busy op=%0d got=%b exp=%b", i, op, Busy, op <= 3'd3);
            end
            model(op, a, b, mhi, mlo, nhi, nlo);
            lat = (op <= 3'd3) ? (op[1] ? DC : MC) : 0;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                drive(1'b0, 3'd7, 32'd0, 32'd0);
                #1;
                checks++;
                if (Busy !== 1'b1) begin failures++; $display("FAIL rnd%0d_busy_c%0d got=%b exp=1", i, c, Busy); end
            end
            @(negedge clk);
            drive(1'b0, 3'd7, 32'd0, 32'd0);
            mhi = nhi;
            mlo = nlo;
        end
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== mhi || LO !== mlo) begin
            failures++;
            $display("FAIL rnd_final got=%h/%h busy=%b exp=%h/%h busy=0", HI, LO, Busy, mhi, mlo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_reset_abort();
        test_ignore_start();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the pipelined MIPS core. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` into private HI/LO registers over a fixed multi-cycle latency. It generates the `Busy` stall that freezes the program counter and the front-end pipeline registers while an operation is in flight. It sits beside the ALU in the E stage; `Busy` is consumed by the PC register and the D/E hazard logic.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: execution cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: execution cycles for `div`/`divu`.

Ports:
- `clk`  input  1: single system clock, rising edge.
- `reset`  input  1: synchronous, active-high; one clock, one reset, no other clocking.
- `Start`  input  1: E-stage instruction is an MD op; qualified by `MDOp`.
- `MDOp`  input  3: 0 `mult`, 1 `multu`, 2 `div`, 3 `divu`, 4 `mthi`, 5 `mtlo`; 6–7 no-op.
- `RsData`  input  32: operand A (dividend, or the value for `mthi`/`mtlo`).
- `RtData`  input  32: operand B (divisor).
- `HI`  output  32: HI register.
- `LO`  output  32: LO register.
- `Busy`  output  1: stall request to the PC and the pipeline.

## Operation
States:
- `IDLE`: `Count == 0`.
- `RUN`: `Count != 0`, with operation and latched operands held.

In `IDLE` with `Start`:
- Ops 0–3:
  - latch `RsData`, `RtData` and `MDOp`.
  - load `Count` with `MULT_CYCLES` or `DIV_CYCLES`.
  - enter `RUN`.
- Op 4/5: write `RsData` to HI/LO at this edge; no `RUN`, no stall.
- Op 6/7: ignored.

In `RUN`:
- `Count` decrements every cycle.
- On the edge where `Count == 1`, HI/LO are written from the latched operands and the block returns to `IDLE`.

`Start` while in `RUN` is ignored; the pipeline guarantees it is stalled, and the bench checks the ignore.

`Busy = (Start & MDOp <= 3) | (Count != 0)`. It is combinational on `Start` so the stall covers the issue cycle.

Arithmetic (computed from the latched operands):
- `mult`: 64-bit signed product; HI = [63:32], LO = [31:0].
- `multu`: same, unsigned.
- `div`: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - `0x80000000 / -1` gives LO = `0x80000000`, HI = 0.
- `divu`: unsigned quotient and remainder.
- Divide by zero (signed or unsigned): HI and LO are left unchanged. The block still spends `DIV_CYCLES` and still raises `Busy`.

Reset:
- HI = 0, LO = 0, `Count = 0`; `Busy` low unless `Start` is asserted in that cycle.
- Reset mid-operation aborts it; HI/LO are not written.
- Reset has priority over `Start` on the same edge.

## Timing
- A `mult` issued with `Start` in cycle 0:
  - `Busy` is high in cycles 0–5.
  - HI/LO are written at the end of cycle 5.
  - New values are visible and `Busy` is low in cycle 6.
- `div` follows the same pattern over cycles 0–10, with results visible in cycle 11.
- Total occupancy is latency + 1 cycles counted from the `Start` cycle.
- `mthi`/`mtlo`: value visible the cycle after `Start`; `Busy` stays low.
- HI/LO are registered outputs. Forwarding of a same-cycle `mthi` into an `mfhi` is the hazard unit's job, not this block's.
- Back-to-back: a new op is accepted in the first cycle `Busy` is low from `Count`, i.e. cycle 6 after a `mult`.

## Structure
- Shared package `md_pkg` holds:
  - `MDOp` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`).
  - default latencies.
- Sub-module `md_counter`: loadable down-counter that flags `Count == 1` and `Count != 0`.
- Arithmetic is a combinational block inside `md_ctrl`, driven by the latched operands.

## Test plan
- `mult`, Rs = `0xFFFFFFFE` (−2), Rt = 3, Start in cycle 0:
  - `Busy` high in cycles 0–5.
  - HI = `0xFFFFFFFF`, LO = `0xFFFFFFFA` in cycle 6.
- `multu` with the same operands:
  - HI = `0x00000002`, LO = `0xFFFFFFFA`.
- `div`, Rs = −7, Rt = 2:
  - `Busy` high in cycles 0–10.
  - LO = `0xFFFFFFFD` (−3), HI = `0xFFFFFFFF` (−1) in cycle 11.
  - Then `divu` 7/0: HI/LO unchanged after 11 cycles.
- `mthi` with Rs = `0x12345678`:
  - `Busy` never high.
  - HI = `0x12345678` next cycle; then `mtlo` sets LO.
- Start `div` and assert `reset` in cycle 4:
  - HI = LO = 0 and `Busy` low from cycle 5.
  - A second `Start` during `RUN` of a `mult` is ignored; results match the first op only.
- `div` with `0x80000000 / 0xFFFFFFFF`:
  - LO = `0x80000000`, HI = 0.
